// File: rtl/mem_responder.sv
// Main-memory responder: programmable-latency 4-beat read bursts, byte-masked single-beat writes.
// Optional MEM_CRIT_WORD_FIRST_EN returns the requested beat first, wrapping within the line.
module mem_responder #(
  parameter int ADDR_BITS  = 28,
  parameter int DATA_BITS  = 128,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   mem_req_valid,
  output logic                   mem_req_ready,
  input  logic [ADDR_BITS-1:0]   mem_req_addr,
  input  logic                   mem_req_rw,
  input  logic                   mem_req_data_valid,
  output logic                   mem_req_data_ready,
  input  logic [DATA_BITS-1:0]   mem_req_data_bits,
  input  logic [DATA_BITS/8-1:0] mem_req_data_mask,
  output logic                   mem_resp_valid,
  output logic [DATA_BITS-1:0]   mem_resp_data
);
  localparam int MASK_BITS = DATA_BITS / 8;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAT    = 2'd1;
  localparam logic [1:0] S_RBURST = 2'd2;
  localparam logic [1:0] S_WDATA  = 2'd3;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);

  logic [1:0]            state;
  logic [3:0]            lat_cnt;
  logic [1:0]            beat;
  logic [1:0]            beat_idx;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic                  req_fire;
  logic                  data_fire;
  logic                  unused_bits;

  logic [DATA_BITS-1:0] store [2**DEPTH_LOG2];

  // Outputs are gated by reset_n so they read 0 for the whole reset pulse.
  assign mem_req_ready      = reset_n & (state == S_IDLE);
  assign mem_req_data_ready = reset_n & (state == S_WDATA);
  assign mem_resp_valid     = reset_n & (state == S_RBURST);
  assign req_fire           = mem_req_valid & mem_req_ready;
  assign data_fire          = mem_req_data_valid & mem_req_data_ready;

`ifdef MEM_CRIT_WORD_FIRST_EN
  assign beat_idx = addr_q[1:0] + beat;
`else
  assign beat_idx = beat;
`endif

  assign rd_addr       = {addr_q[DEPTH_LOG2-1:2], beat_idx};
  assign mem_resp_data = mem_resp_valid ? store[rd_addr] : '0;

  // High address bits alias; low beat bits only matter with critical-word-first.
  assign unused_bits = ^{mem_req_addr[ADDR_BITS-1:DEPTH_LOG2], addr_q[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      addr_q  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_fire) begin
          addr_q <= mem_req_addr[DEPTH_LOG2-1:0];
          if (mem_req_rw) begin
            state <= S_WDATA;
          end else begin
            state   <= S_LAT;
            lat_cnt <= LAT_INIT;
          end
        end
        S_LAT: begin
          if (lat_cnt == '0) begin
            state <= S_RBURST;
            beat  <= '0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_RBURST: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) state <= S_IDLE;
        end
        S_WDATA: if (data_fire) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately not reset; data_fire is already blocked during reset.
  always_ff @(posedge clk) begin
    if (data_fire) begin
      for (int i = 0; i < MASK_BITS; i++) begin
        if (mem_req_data_mask[i]) store[addr_q][8*i +: 8] <= mem_req_data_bits[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: expected beats are queued when a read is issued
// and popped by a negedge monitor; protocol timing is checked inline by the tasks.
module tb_mem_responder;
  localparam int AB  = 28;
  localparam int DB  = 128;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AB-1:0] mem_req_addr;
  logic          mem_req_rw;
  logic          mem_req_data_valid;
  logic          mem_req_data_ready;
  logic [DB-1:0] mem_req_data_bits;
  logic [15:0]   mem_req_data_mask;
  logic          mem_resp_valid;
  logic [DB-1:0] mem_resp_data;

  int total = 0;
  int bad   = 0;
  logic [DB-1:0] model [256];
  logic [DB-1:0] exp_q [$];

  mem_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .DEPTH_LOG2(8), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
    .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DB-1:0] got, input logic [DB-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Monitor: every response beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_resp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 1, 0);
        else chk("beat_data", mem_resp_data, exp_q.pop_front());
      end else if (mem_resp_data !== '0) begin
        chk("idle_data_zero", mem_resp_data, 0);
      end
    end
  end

  // All tasks start and end just after a negedge with the DUT in IDLE.
  task automatic do_write(input logic [AB-1:0] a, input logic [DB-1:0] d, input logic [15:0] m);
    mem_req_valid = 1; mem_req_rw = 1; mem_req_addr = a;
    chk("wr_req_ready", mem_req_ready, 1);
    @(posedge clk); @(negedge clk);
    mem_req_valid = 0;
    chk("wdata_ready", mem_req_data_ready, 1);
    chk("wdata_req_ready", mem_req_ready, 0);
    mem_req_data_valid = 1; mem_req_data_bits = d; mem_req_data_mask = m;
    @(posedge clk);
    for (int i = 0; i < 16; i++) if (m[i]) model[a[7:0]][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    mem_req_data_valid = 0;
    chk("wr_done_ready", mem_req_ready, 1);
  endtask

  task automatic push_read(input logic [AB-1:0] a);
    logic [1:0] idx;
    for (int b = 0; b < 4; b++) begin
`ifdef MEM_CRIT_WORD_FIRST_EN
      idx = a[1:0] + 2'(b);
`else
      idx = 2'(b);
`endif
      exp_q.push_back(model[{a[7:2], idx}]);
    end
  endtask

  task automatic start_read(input logic [AB-1:0] a);
    push_read(a);
    mem_req_valid = 1; mem_req_rw = 0; mem_req_addr = a;
    chk("rd_req_ready", mem_req_ready, 1);
    @(posedge clk); @(negedge clk);
    mem_req_valid = 0;
  endtask

  task automatic do_read(input logic [AB-1:0] a);
    start_read(a);
    for (int k = 0; k < LAT; k++) begin
      chk("lat_valid", mem_resp_valid, 0);
      chk("lat_ready", mem_req_ready, 0);
      @(negedge clk);
    end
    for (int b = 0; b < 4; b++) begin
      chk("burst_valid", mem_resp_valid, 1);
      chk("burst_ready", mem_req_ready, 0);
      @(negedge clk);
    end
    chk("post_valid", mem_resp_valid, 0);
    chk("post_ready", mem_req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; mem_req_valid = 1; mem_req_addr = '0; mem_req_rw = 0;
    mem_req_data_valid = 0; mem_req_data_bits = '0; mem_req_data_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", mem_req_ready, 0);
    chk("rst_data_ready", mem_req_data_ready, 0);
    chk("rst_resp_valid", mem_resp_valid, 0);
    chk("rst_resp_data", mem_resp_data, 0);
    mem_req_valid = 0;
    reset_n = 1;
    @(negedge clk);
    chk("rel_req_ready", mem_req_ready, 1);

    // Prefill every beat of the lines read later.
    for (int l = 1; l <= 3; l++)
      for (int b = 0; b < 4; b++)
        do_write(AB'(l * 16 + b), {$urandom, $urandom, $urandom, $urandom}, 16'hFFFF);

    do_write(28'h10, 128'h0123456789ABCDEF0123456789ABCDEF, 16'hFFFF);
    do_read(28'h10);

    do_write(28'h21, {16{8'hAA}}, 16'hFFFF);
    do_write(28'h21, {16{8'h55}}, 16'h000F);
    chk("masked_model", model[8'h21], {{12{8'hAA}}, 32'h5555_5555});
    do_read(28'h20);

    // Write data offered outside WDATA must be ignored.
    mem_req_data_valid = 1; mem_req_data_bits = '1; mem_req_data_mask = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_data_ready", mem_req_data_ready, 0);
    end
    mem_req_data_valid = 0;
    do_read(28'h30);
    do_write(28'h31, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 16'hFFFF);
    do_read(28'h30);

    do_read(28'h12);
    do_read(28'h33);

    // High address bits alias onto the same storage.
    do_write(28'hABCD_E22, 128'hCAFE_F00D_1234_5678_9ABC_DEF0_0F0F_F0F0, 16'h0FF0);
    do_read(28'h20);

    // Reset during beat 1 drops valid at once and discards the rest of the burst.
    start_read(28'h10);
    repeat (LAT + 1) @(negedge clk);
    #1 reset_n = 0;
    #1;
    chk("midrst_valid", mem_resp_valid, 0);
    chk("midrst_data", mem_resp_data, 0);
    chk("midrst_ready", mem_req_ready, 0);
    chk("midrst_q_left", 128'(exp_q.size()), 2);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("midrst_idle", mem_req_ready, 1);
    do_read(28'h11);

    @(negedge clk);
    chk("q_empty", 128'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory responder for the cache's memory port; the target end of the mem_req / mem_req_data / mem_resp protocol.
- Accepts 128-bit-granule read requests and returns a 4-beat line burst after a programmable latency.
- Accepts single-beat byte-masked writes.
- Serves as the synthesizable backing store for core-level simulation and FPGA bring-up, instantiated opposite the cache.

Parameters:
ADDR_BITS, 28, width of mem_req_addr (128-bit beat address)
DATA_BITS, 128, beat width (`MEM_DATA_BITS)
DEPTH_LOG2, 8, log2 of storage depth in beats (256 beats = 64 lines of 4 beats)
LATENCY, 4, cycles from read-request accept to first response beat; legal range 1..15

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
mem_req_valid  in  1  request valid from initiator
mem_req_ready  out  1  responder can accept a request
mem_req_addr  in  ADDR_BITS  beat address
mem_req_rw  in  1  1 = write, 0 = read
mem_req_data_valid  in  1  write data valid
mem_req_data_ready  out  1  responder can accept write data
mem_req_data_bits  in  DATA_BITS  write data
mem_req_data_mask  in  DATA_BITS/8  byte enables, bit i covers bits [8i+7:8i]
mem_resp_valid  out  1  response beat valid
mem_resp_data  out  DATA_BITS  response beat

Behaviour:
- Reset: one clock, reset asynchronous and active-low. While reset_n=0, all outputs are 0, the FSM is in IDLE, and the latency and beat counters are 0. Storage is not reset.
- Reset mid-operation aborts any pending burst or write immediately; mem_resp_valid drops asynchronously. No partial write is committed unless its data fire edge has already passed.
- FSM states:
  - IDLE: mem_req_ready=1. On mem_req_valid && ready, latch addr[DEPTH_LOG2-1:0] and rw.
    - rw=0: go to LAT, counter = LATENCY-1.
    - rw=1: go to WDATA.
  - LAT: mem_req_ready=0. Decrement the counter. At 0, go to RBURST with beat=0.
  - RBURST: mem_resp_valid=1 and mem_resp_data = store[{line, beat_idx}] for 4 consecutive cycles, with no gaps and no backpressure. After beat 3, return to IDLE; mem_req_ready rises the cycle after the last beat.
  - WDATA: mem_req_data_ready=1, mem_req_ready=0. On mem_req_data_valid && ready, write each byte with its mask bit set; unmasked bytes are unchanged. Return to IDLE next cycle. No response beat is produced for a write.
- Read timing: request accepted at edge T; beat 0 valid in cycle T+LATENCY; beats 1..3 in cycles T+LATENCY+1..+3.
- Line/beat: line = latched_addr[DEPTH_LOG2-1:2]. Default beat_idx = beat (order 0,1,2,3 regardless of addr[1:0]).
- Address bits at or above DEPTH_LOG2 are ignored (aliasing); no error is raised.
- mem_req_data_valid outside WDATA is ignored; data is never accepted in the same cycle as its request.
- A write commits at the data fire edge; a read accepted afterwards returns the new data.
- Back-to-back requests: the next request can be accepted in the IDLE cycle immediately following burst end or write commit.
- mem_resp_data is 0 whenever mem_resp_valid=0.

Optional Feature:
MEM_CRIT_WORD_FIRST_EN
- Defined: beat_idx = (latched_addr[1:0] + beat) mod 4. The requested beat is returned first and the order wraps within the line; e.g. addr[1:0]=2 gives order 2,3,0,1.
- Undefined: aligned order 0,1,2,3 as in Behaviour. No port or latency change.

Test Plan:
- Reset: hold reset_n=0 with mem_req_valid=1 -> all outputs 0. Release -> mem_req_ready=1 next cycle.
- Write then read: write addr=0x10, data=0x0123..CDEF, mask=0xFFFF; then read addr=0x10 (LATENCY=4) -> mem_resp_valid for exactly 4 cycles starting 4 cycles after accept; beat 0 = written data; mem_req_ready=0 during LAT and RBURST.
- Masked write: prefill beat 0x21 = all 0xAA bytes; write data all 0x55 with mask=0x000F; read line 0x20 -> beat 1 = 0xAA..AA_5555_5555 (low 4 bytes 0x55, rest 0xAA).
- Data-before-WDATA: assert mem_req_data_valid in IDLE with no request -> mem_req_data_ready=0 and storage unchanged. Then a normal write followed by a read of the same address returns the new data.
- Reset mid-burst: deassert reset_n during beat 1 -> mem_resp_valid=0 immediately. After release -> IDLE, and a new read returns the full 4 beats.
- MEM_CRIT_WORD_FIRST_EN defined: read addr=0x12 after prefilling beats 0x10..0x13 with distinct values -> response order is the contents of 0x12, 0x13, 0x10, 0x11. Undefined: order is 0x10..0x13.
